// File: rtl/divisor_subtrator_4bits_pkg.sv
// Shared types for the adder/mux/divider datapath family.
package sommux_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    localparam int WIDTH_DEF = 4;

endpackage

// File: rtl/mux2x1_4bits.sv
// 2x1 operand multiplexer shared with the adder datapath: sel=0 picks a, sel=1 picks b.
module mux2x1_4bits
    import sommux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign y[gi] = sel ? b[gi] : a[gi];
        end
    endgenerate

endmodule

// File: rtl/subtrator_4bits.sv
// Combinational unsigned subtractor; caller guarantees a >= b so no borrow out is needed.
module subtrator_4bits
    import sommux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff
);

    assign diff = a - b;

endmodule

// File: rtl/divisor_subtrator_4bits.sv
// Sequential unsigned divider by repeated subtraction, one subtraction per clock.
// Divisor is taken from ib or ic through the shared mux; start/done handshake.
module divisor_subtrator_4bits
    import sommux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ia,
    input  logic [WIDTH-1:0] ib,
    input  logic [WIDTH-1:0] ic,
    input  logic             select,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_t       state_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_next;
    logic [WIDTH-1:0] rem_next;
    logic             busy_reg;
    logic             done_reg;
    logic             dbz_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;

    mux2x1_4bits #(.WIDTH(WIDTH)) u_mux (
        .a   (ib),
        .b   (ic),
        .sel (select),
        .y   (dvs_next)
    );

    subtrator_4bits #(.WIDTH(WIDTH)) u_sub (
        .a    (rem_reg),
        .b    (dvs_reg),
        .diff (rem_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rem_reg       <= '0;
            dvs_reg       <= '0;
            quo_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            dbz_reg       <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        rem_reg  <= ia;
                        dvs_reg  <= dvs_next;
                        quo_reg  <= '0;
                        dbz_reg  <= 1'b0;
                        busy_reg <= 1'b1;
                        if (dvs_next == '0) begin
                            // Zero divisor: skip CALC and report saturated quotient.
                            state_reg     <= DONE;
                            done_reg      <= 1'b1;
                            dbz_reg       <= 1'b1;
                            quotient_reg  <= '1;
                            remainder_reg <= ia;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (rem_reg >= dvs_reg) begin
                        rem_reg <= rem_next;
                        quo_reg <= quo_reg + WIDTH'(1);
                    end else begin
                        // Results are published on the same edge done rises.
                        state_reg     <= DONE;
                        done_reg      <= 1'b1;
                        quotient_reg  <= quo_reg;
                        remainder_reg <= rem_reg;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;

endmodule

// File: tb/tb_divisor_subtrator_4bits.sv
// Scoreboard bench for the repeated-subtraction divider: driver pushes expectations,
// a negedge monitor pops and checks them whenever done pulses.
module tb_divisor_subtrator_4bits;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] ia = '0, ib = '0, ic = '0;
    logic       select = 1'b0;
    logic       busy, done, div_by_zero;
    logic [3:0] quotient, remainder;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    divisor_subtrator_4bits dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ia          (ia),
        .ib          (ib),
        .ic          (ic),
        .select      (select),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", int'(quotient), int'(e.q));
                check("remainder", int'(remainder), int'(e.r));
                check("div_by_zero", int'(div_by_zero), int'(e.dbz));
                check("done_cycle", cyc, e.cyc);
                $display("[TB] done q=%0d r=%0d dbz=%0d at cycle %0d", quotient, remainder,
                         div_by_zero, cyc);
            end
        end
    end

    // Issue one start; optionally push the expectation; return the accept edge number.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic sel, input logic push,
                         input logic [3:0] q, input logic [3:0] r, input logic dbz,
                         output int acc);
        exp_t e;
        @(negedge clk);
        ia = a; ib = b; ic = c; select = sel; start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) begin
            e.q = q; e.r = r; e.dbz = dbz;
            e.cyc = dbz ? acc : acc + int'(q) + 1;
            sb.push_back(e);
        end
        $display("[TB] start ia=%0d ib=%0d ic=%0d sel=%0d accepted at edge %0d", a, b, c, sel, acc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int acc;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_q", int'(quotient), 0);
        check("rst_r", int'(remainder), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: 13/4 via ib
        issue(4'd13, 4'd4, 4'd9, 1'b0, 1'b1, 4'd3, 4'd1, 1'b0, acc);
        check("t1_busy", int'(busy), 1);
        wait_done("t1");
        check("t1_idle_busy", int'(busy), 0);
        check("t1_hold_q", int'(quotient), 3);

        // 2: 15/1 via ic, worst case
        issue(4'd15, 4'd7, 4'd1, 1'b1, 1'b1, 4'd15, 4'd0, 1'b0, acc);
        wait_done("t2");

        // 3: 3/7
        issue(4'd3, 4'd7, 4'd0, 1'b0, 1'b1, 4'd0, 4'd3, 1'b0, acc);
        wait_done("t3");

        // 4: divide by zero, then recovery
        issue(4'd9, 4'd0, 4'd5, 1'b0, 1'b1, 4'hF, 4'd9, 1'b1, acc);
        wait_done("t4a");
        check("t4_dbz_hold", int'(div_by_zero), 1);
        issue(4'd9, 4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 4'd0, 1'b0, acc);
        wait_done("t4b");

        // 5: start while busy and operand changes are ignored
        issue(4'd14, 4'd2, 4'd0, 1'b0, 1'b1, 4'd7, 4'd0, 1'b0, acc);
        @(negedge clk);
        ia = 4'd5; ib = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ia = 4'd1; ib = 4'd1;
        wait_done("t5a");
        issue(4'd5, 4'd5, 4'd0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, acc);
        wait_done("t5b");

        // 6: reset mid-CALC, no done pulse expected
        issue(4'd15, 4'd1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, acc);
        while (cyc < acc + 6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", int'(busy), 0);
        check("t6_done", int'(done), 0);
        check("t6_q", int'(quotient), 0);
        check("t6_r", int'(remainder), 0);
        check("t6_dbz", int'(div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_still_idle", int'(busy), 0);
        issue(4'd8, 4'd3, 4'd0, 1'b0, 1'b1, 4'd2, 4'd2, 1'b0, acc);
        wait_done("t6b");

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
